// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit width, maximum digit value and the
// single-digit step/saturation helpers used by the counter chain.
package bcd_pkg;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    // One BCD digit step. When i_cin is low the digit passes through.
    // Returns {carry/borrow out, next digit}.
    function automatic logic [4:0] bcd_digit_step(
        input logic [3:0] i_digit,
        input logic       i_up,
        input logic       i_cin
    );
        logic [4:0] r_res;
        if (!i_cin) begin
            r_res = {1'b0, i_digit};
        end else if (i_up) begin
            if (i_digit >= BCD_MAX_DIGIT) begin
                r_res = {1'b1, 4'd0};
            end else begin
                r_res = {1'b0, i_digit + 4'd1};
            end
        end else begin
            if (i_digit == 4'd0) begin
                r_res = {1'b1, BCD_MAX_DIGIT};
            end else begin
                r_res = {1'b0, i_digit - 4'd1};
            end
        end
        return r_res;
    endfunction

    // Clamp a raw nibble into the legal BCD range 0..9.
    function automatic logic [3:0] bcd_digit_sat(input logic [3:0] i_digit);
        logic [3:0] r_res;
        if (i_digit > BCD_MAX_DIGIT) begin
            r_res = BCD_MAX_DIGIT;
        end else begin
            r_res = i_digit;
        end
        return r_res;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Clock divider producing a one-cycle internal tick every DIV enabled
// cycles. Pausing freezes the phase so a resumed period is not shortened
// or stretched.
module tick_gen #(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_HZ  = 1
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEN,
    input  logic iCLR,
    output logic oTICK_INT
);

    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: CLK_FREQ/TICK_HZ must be at least 2");
    end

    logic [CW-1:0] r_div;
    logic          w_at_end;

    assign w_at_end  = (r_div == DIV_M1);
    assign oTICK_INT = iEN & w_at_end;

    // Divider phase: restart on clear, advance only while enabled.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_div <= '0;
        end else if (iCLR) begin
            r_div <= '0;
        end else if (iEN) begin
            if (w_at_end) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + ONE;
            end
        end else begin
            r_div <= r_div;
        end
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// N-digit BCD up/down counter with a rotating one-hot LED ring, stepped
// by a divided tick. Every output is a flop.
module bcd_tick_counter
    import bcd_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int TICK_HZ    = 1,
    parameter int NUM_DIGITS = 4,
    parameter int RING_WIDTH = 8
) (
    input  logic                              iCLK,
    input  logic                              iRST,
    input  logic                              iEN,
    input  logic                              iUP,
    input  logic                              iCLR,
    input  logic                              iLOAD,
    input  logic [BCD_DIGIT_W*NUM_DIGITS-1:0] iLOAD_VAL,
    output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] oBCD,
    output logic [RING_WIDTH-1:0]             oRING,
    output logic                              oTICK,
    output logic                              oWRAP
);

    localparam int BW = BCD_DIGIT_W * NUM_DIGITS;
    localparam logic [RING_WIDTH-1:0] RING_RESET = RING_WIDTH'(1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("bcd_tick_counter: NUM_DIGITS must be 1..8");
    end
    if (RING_WIDTH < 2) begin : g_bad_ring
        $error("bcd_tick_counter: RING_WIDTH must be at least 2");
    end

    logic                  w_tick;
    logic [NUM_DIGITS:0]   w_carry;
    logic [BW-1:0]         w_next_bcd;
    logic [BW-1:0]         w_load_sat;
    logic [RING_WIDTH-1:0] w_next_ring;
    logic [BW-1:0]         r_bcd;
    logic [RING_WIDTH-1:0] r_ring;
    logic                  r_tick;
    logic                  r_wrap;

    // Load and clear both restart the divider phase.
    tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_HZ  (TICK_HZ)
    ) u_tick_gen (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iEN       (iEN),
        .iCLR      (iCLR | iLOAD),
        .oTICK_INT (w_tick)
    );

    // Digit 0 always receives the step request; carries ripple upward.
    assign w_carry[0] = 1'b1;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [4:0] w_step;
        assign w_step = bcd_digit_step(r_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W], iUP, w_carry[gi]);
        assign w_next_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W] = w_step[3:0];
        assign w_carry[gi+1] = w_step[4];
        assign w_load_sat[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
            bcd_digit_sat(iLOAD_VAL[gi*BCD_DIGIT_W +: BCD_DIGIT_W]);
    end

    // Ring rotates left when counting up, right when counting down.
    always_comb begin
        w_next_ring = r_ring;
        if (iUP) begin
            w_next_ring = {r_ring[RING_WIDTH-2:0], r_ring[RING_WIDTH-1]};
        end else begin
            w_next_ring = {r_ring[0], r_ring[RING_WIDTH-1:1]};
        end
    end

    // Count/ring state and strobes, priority clear > load > tick.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_bcd  <= '0;
            r_ring <= RING_RESET;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (iCLR) begin
            r_bcd  <= '0;
            r_ring <= RING_RESET;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (iLOAD) begin
            r_bcd  <= w_load_sat;
            r_ring <= r_ring;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_tick) begin
            r_bcd  <= w_next_bcd;
            r_ring <= w_next_ring;
            r_tick <= 1'b1;
            r_wrap <= w_carry[NUM_DIGITS];
        end else begin
            r_bcd  <= r_bcd;
            r_ring <= r_ring;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign oBCD  = r_bcd;
    assign oRING = r_ring;
    assign oTICK = r_tick;
    assign oWRAP = r_wrap;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Self-checking bench for bcd_tick_counter (DIV=10, 2 digits, 4-bit ring).
// A counting model (integer count, phase and ring position) runs beside
// the DUT; directed steps add constant expectations at key points.
module tb_bcd_tick_counter;

    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] o_bcd;
    logic [3:0] o_ring;
    logic       o_tick;
    logic       o_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_phase = 0;
    int m_count = 0;
    int m_pos   = 0;
    int m_tick  = 0;
    int m_wrap  = 0;

    bcd_tick_counter #(
        .CLK_FREQ   (10),
        .TICK_HZ    (1),
        .NUM_DIGITS (2),
        .RING_WIDTH (4)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iEN       (en),
        .iUP       (up),
        .iCLR      (clr),
        .iLOAD     (load),
        .iLOAD_VAL (load_val),
        .oBCD      (o_bcd),
        .oRING     (o_ring),
        .oTICK     (o_tick),
        .oWRAP     (o_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_bcd();
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(m_count / 10);
        lo = 4'(m_count % 10);
        return {hi, lo};
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_count = 0;
        m_pos   = 0;
        m_tick  = 0;
        m_wrap  = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".bcd"},  {24'd0, o_bcd},  {24'd0, model_bcd()});
        chk({tag, ".ring"}, {28'd0, o_ring}, 32'd1 << m_pos);
        chk({tag, ".tick"}, {31'd0, o_tick}, 32'(m_tick));
        chk({tag, ".wrap"}, {31'd0, o_wrap}, 32'(m_wrap));
    endtask

    // One clock with the given inputs; model follows the behavioural rules.
    task automatic cycle(input logic c_en, input logic c_up, input logic c_clr,
                         input logic c_load, input logic [7:0] c_val, input string tag);
        int hi;
        int lo;
        en = c_en; up = c_up; clr = c_clr; load = c_load; load_val = c_val;
        @(posedge clk);
        #1;
        m_tick = 0;
        m_wrap = 0;
        if (c_clr) begin
            m_phase = 0; m_count = 0; m_pos = 0;
        end else if (c_load) begin
            hi = int'(c_val[7:4]); lo = int'(c_val[3:0]);
            if (hi > 9) hi = 9;
            if (lo > 9) lo = 9;
            m_count = hi * 10 + lo;
            m_phase = 0;
        end else if (c_en) begin
            if (m_phase == DIV - 1) begin
                m_phase = 0;
                m_tick  = 1;
                if (c_up) begin
                    m_wrap  = (m_count == 99) ? 1 : 0;
                    m_count = (m_count + 1) % 100;
                    m_pos   = (m_pos + 1) % 4;
                end else begin
                    m_wrap  = (m_count == 0) ? 1 : 0;
                    m_count = (m_count + 99) % 100;
                    m_pos   = (m_pos + 3) % 4;
                end
            end else begin
                m_phase++;
            end
        end
        check_model(tag);
    endtask

    task automatic run(input int n, input logic c_en, input logic c_up, input string tag);
        for (int k = 0; k < n; k++) cycle(c_en, c_up, 1'b0, 1'b0, 8'h00, tag);
    endtask

    initial begin
        logic r_en;
        logic r_up;
        logic r_clr;
        logic r_load;
        logic [7:0] r_val;

        // reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");

        // 1: run up, first tick 10 cycles after release
        rst = 1'b0;
        run(9, 1'b1, 1'b1, "t1_pre");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "t1_first");
        chk("t1_first_tick", {31'd0, o_tick}, 32'd1);
        chk("t1_first_bcd",  {24'd0, o_bcd},  32'h01);
        chk("t1_first_ring", {28'd0, o_ring}, 32'b0010);
        run(40, 1'b1, 1'b1, "t1_run");
        chk("t1_bcd5",  {24'd0, o_bcd},  32'h05);
        chk("t1_ring5", {28'd0, o_ring}, 32'b0010);

        // 2: load 98, count up through wrap
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'h98, "t2_load");
        run(10, 1'b1, 1'b1, "t2_99");
        chk("t2_bcd99",  {24'd0, o_bcd},  32'h99);
        chk("t2_nowrap", {31'd0, o_wrap}, 32'd0);
        run(10, 1'b1, 1'b1, "t2_00");
        chk("t2_bcd00", {24'd0, o_bcd},  32'h00);
        chk("t2_wrap",  {31'd0, o_wrap}, 32'd1);
        chk("t2_tick",  {31'd0, o_tick}, 32'd1);

        // 3: clear, count down from 00
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, "t3_clr");
        run(10, 1'b1, 1'b0, "t3_down");
        chk("t3_bcd99", {24'd0, o_bcd},  32'h99);
        chk("t3_wrap",  {31'd0, o_wrap}, 32'd1);
        chk("t3_ring",  {28'd0, o_ring}, 32'b1000);

        // 4: pause at divider 6 for 25 cycles
        run(6, 1'b1, 1'b0, "t4_pre");
        run(25, 1'b0, 1'b0, "t4_pause");
        chk("t4_hold", {24'd0, o_bcd}, 32'h99);
        run(3, 1'b1, 1'b0, "t4_resume");
        chk("t4_no_tick_yet", {31'd0, o_tick}, 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "t4_tick");
        chk("t4_tick4", {31'd0, o_tick}, 32'd1);
        chk("t4_bcd98", {24'd0, o_bcd},  32'h98);

        // 5: clear+load on a due tick edge, then saturating load
        run(9, 1'b1, 1'b1, "t5_pre");
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, "t5_clr_load");
        chk("t5_bcd00", {24'd0, o_bcd},  32'h00);
        chk("t5_ring",  {28'd0, o_ring}, 32'b0001);
        chk("t5_tick0", {31'd0, o_tick}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, "t5_load_sat");
        chk("t5_bcd93", {24'd0, o_bcd}, 32'h93);

        // 6: asynchronous reset mid-period
        run(4, 1'b1, 1'b1, "t6_pre");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_model("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(9, 1'b1, 1'b1, "t6_post");
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, "t6_first");
        chk("t6_first_tick", {31'd0, o_tick}, 32'd1);
        chk("t6_first_bcd",  {24'd0, o_bcd},  32'h01);

        // randomized traffic against the model
        r_up = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            r_en   = ($urandom % 8) != 0;
            if (($urandom % 50) == 0) r_up = ~r_up;
            r_clr  = ($urandom % 120) == 0;
            r_load = ($urandom % 60) == 0;
            r_val  = 8'($urandom);
            if (($urandom % 2) == 0) r_val[3:0] = 4'd9;
            cycle(r_en, r_up, r_clr, r_load, r_val, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
